// File: rtl/sram_rd_streamer_pkg.sv
// Shared types and sizing for the SRAM read streamer (sram_rd_streamer).
package sram_rds_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } rds_state_e;

   localparam int unsigned RDS_FIFO_DEPTH = 2;
   localparam int unsigned RDS_PTR_W      = $clog2(RDS_FIFO_DEPTH);
   localparam int unsigned RDS_CNT_W      = $clog2(RDS_FIFO_DEPTH + 1);

endpackage

// File: rtl/sram_rd_streamer_fifo.sv
// Small first-word-fall-through FIFO holding returned SRAM words until the
// stream consumer accepts them; push and pop may happen in the same cycle.
module sram_rds_fifo
   import sram_rds_pkg::*;
#(
   parameter int unsigned W = 128
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_push,
   input  logic [W-1:0]         i_wdata,
   input  logic                 i_pop,
   output logic [W-1:0]         o_rdata,
   output logic [RDS_CNT_W-1:0] o_count
);

   logic [W-1:0]         mem [RDS_FIFO_DEPTH];
   logic [RDS_PTR_W-1:0] wr_ptr;
   logic [RDS_PTR_W-1:0] rd_ptr;
   logic [RDS_CNT_W-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int unsigned i = 0; i < RDS_FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (i_push) begin
            mem[wr_ptr] <= i_wdata;
            wr_ptr      <= wr_ptr + RDS_PTR_W'(1);
         end
         if (i_pop) begin
            rd_ptr <= rd_ptr + RDS_PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   cnt <= cnt + RDS_CNT_W'(1);
            2'b01:   cnt <= cnt - RDS_CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign o_rdata = mem[rd_ptr];
   assign o_count = cnt;

endmodule

// File: rtl/sram_rd_streamer.sv
// Turns a (base, count) command into SRAM reads and streams the words out.
// Optional per-transfer address stride is enabled by SRAM_RDS_STRIDE_EN.
module sram_rd_streamer
   import sram_rds_pkg::*;
#(
   parameter int unsigned ADR_W  = 10,
   parameter int unsigned SRAM_W = 128,
   parameter int unsigned CNT_W  = ADR_W + 1
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic [ADR_W-1:0]  i_base_addr,
   input  logic [CNT_W-1:0]  i_count,
`ifdef SRAM_RDS_STRIDE_EN
   input  logic [ADR_W-1:0]  i_stride,
`endif
   output logic              o_busy,
   output logic              o_done,
   output logic              o_sram_cen,
   output logic              o_sram_rdwen,
   output logic [ADR_W-1:0]  o_sram_addr,
   input  logic [SRAM_W-1:0] i_sram_rdata,
   output logic [SRAM_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready
);

   rds_state_e           state_q;
   rds_state_e           state_d;
   logic [ADR_W-1:0]     addr_q;
   logic [ADR_W-1:0]     stride_val;
   logic [CNT_W-1:0]     remain_q;
   logic                 pending_q;
   logic                 zero_done_q;
   logic [RDS_CNT_W-1:0] fifo_cnt;
   logic [RDS_CNT_W:0]   occupancy;
   logic                 pop;
   logic                 credit_ok;
   logic                 issue;
   logic                 start_ok;
   logic                 drain_done;

   // Words in flight (SRAM pipeline + FIFO) after this cycle's pop must stay below depth.
   assign pop       = o_valid & i_ready;
   assign occupancy = (RDS_CNT_W+1)'(fifo_cnt) + (RDS_CNT_W+1)'(pending_q)
                    - (RDS_CNT_W+1)'(pop);
   assign credit_ok = occupancy < (RDS_CNT_W+1)'(RDS_FIFO_DEPTH);

   assign start_ok   = (state_q == IDLE) & i_start & (i_count != '0);
   assign drain_done = (state_q == DRAIN) & (fifo_cnt == '0) & !pending_q & !pop;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_ok)                               state_d = ISSUE;
         ISSUE:   if (issue && (remain_q == CNT_W'(1)))      state_d = DRAIN;
         DRAIN:   if (drain_done)                             state_d = IDLE;
         default:                                             state_d = IDLE;
      endcase
   end

   always_comb begin
      issue      = (state_q == ISSUE) & credit_ok;
      o_sram_cen = !issue;
      o_busy     = (state_q != IDLE) & !drain_done;
      o_done     = drain_done | zero_done_q;
   end

`ifdef SRAM_RDS_STRIDE_EN
   logic [ADR_W-1:0] stride_q;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         stride_q <= '0;
      end else if (start_ok) begin
         stride_q <= i_stride;
      end
   end

   assign stride_val = stride_q;
`else
   assign stride_val = ADR_W'(1);
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         addr_q      <= '0;
         remain_q    <= '0;
         pending_q   <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         pending_q   <= issue;
         zero_done_q <= (state_q == IDLE) & i_start & (i_count == '0);
         if (start_ok) begin
            addr_q   <= i_base_addr;
            remain_q <= i_count;
         end else if (issue) begin
            addr_q   <= addr_q + stride_val;
            remain_q <= remain_q - CNT_W'(1);
         end
      end
   end

   assign o_sram_addr  = addr_q;
   assign o_sram_rdwen = 1'b1;

   sram_rds_fifo #(
      .W (SRAM_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_push  (pending_q),
      .i_wdata (i_sram_rdata),
      .i_pop   (pop),
      .o_rdata (o_data),
      .o_count (fifo_cnt)
   );

   assign o_valid = (fifo_cnt != '0);

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Bench for sram_rd_streamer: SRAM model with mem[a]=a, scoreboarded
// addresses/data, table-driven transfers plus count-0 and mid-reset cases.
module tb_sram_rd_streamer;

   localparam int unsigned ADR_W  = 10;
   localparam int unsigned SRAM_W = 128;
   localparam int unsigned CNT_W  = ADR_W + 1;

   logic              clk = 1'b0;
   logic              rstn;
   logic              start;
   logic [ADR_W-1:0]  base;
   logic [CNT_W-1:0]  count;
   logic [ADR_W-1:0]  stride;
   logic              busy, done, cen, rdwen, valid, ready;
   logic [ADR_W-1:0]  addr;
   logic [SRAM_W-1:0] sram_rdata;
   logic [SRAM_W-1:0] data;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_pop_cyc = 0;
   int pops   = 0;
   int stall_cen = 0;

   logic [ADR_W-1:0]  exp_addr_q[$];
   logic [SRAM_W-1:0] exp_data_q[$];

   typedef struct {
      logic [ADR_W-1:0] base;
      logic [CNT_W-1:0] count;
      logic [ADR_W-1:0] stride;
      int               stall;
      int               exp_lat;
      int               exp_cen;
      int               exp_done;
   } vec_t;

   vec_t vecs[$];

   sram_rd_streamer #(
      .ADR_W  (ADR_W),
      .SRAM_W (SRAM_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_start      (start),
      .i_base_addr  (base),
      .i_count      (count),
`ifdef SRAM_RDS_STRIDE_EN
      .i_stride     (stride),
`endif
      .o_busy       (busy),
      .o_done       (done),
      .o_sram_cen   (cen),
      .o_sram_rdwen (rdwen),
      .o_sram_addr  (addr),
      .i_sram_rdata (sram_rdata),
      .o_data       (data),
      .o_valid      (valid),
      .i_ready      (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial sram_rdata = '0;
   always @(posedge clk) begin
      if (!cen) sram_rdata <= SRAM_W'(addr);
   end

   task automatic chk(input string name, input logic [SRAM_W-1:0] act,
                      input logic [SRAM_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (!cen) begin
            if (!ready) stall_cen++;
            chk("sram_rdwen", SRAM_W'(rdwen), 1);
            if (exp_addr_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL sram_addr: unexpected read at %0h", addr);
            end else begin
               chk("sram_addr", SRAM_W'(addr), SRAM_W'(exp_addr_q.pop_front()));
            end
         end
         if (valid && ready) begin
            pops++;
            last_pop_cyc = cyc;
            if (exp_data_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL stream_data: unexpected word %0h", data);
            end else begin
               chk("stream_data", data, exp_data_q.pop_front());
            end
         end
      end
   end

   task automatic load_expect(input logic [ADR_W-1:0] b, input logic [CNT_W-1:0] n,
                              input logic [ADR_W-1:0] st);
      logic [ADR_W-1:0] a;
      a = b;
      for (int i = 0; i < int'(n); i++) begin
         exp_addr_q.push_back(a);
         exp_data_q.push_back(SRAM_W'(a));
         a = a + st;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int e;
      logic [SRAM_W-1:0] d0;
      @(posedge clk); #1;
      load_expect(v.base, v.count, v.stride);
      stall_cen = 0;
      start  = 1'b1;
      base   = v.base;
      count  = v.count;
      stride = v.stride;
      ready  = (v.stall == 0);
      @(posedge clk); #1;
      start = 1'b0;
      e = 1;
      chk("busy_after_start", SRAM_W'(busy), 1);
      chk("cen_after_start", SRAM_W'(cen), 0);
      while (!valid && e < 20) begin
         @(posedge clk); #1; e++;
      end
      chk("first_valid_cycle", SRAM_W'(e), SRAM_W'(v.exp_lat));
      d0 = data;
      if (v.stall > 0) begin
         for (int s = 1; s < v.stall; s++) begin
            @(posedge clk); #1; e++;
            chk("stall_valid", SRAM_W'(valid), 1);
            chk("stall_data_hold", data, d0);
         end
         @(posedge clk); #1; e++;
         chk("stall_data_hold", data, d0);
      end
      chk("stall_cen_cycles", SRAM_W'(stall_cen), SRAM_W'(v.exp_cen));
      ready = 1'b1;
      while (!done && e < 200) begin
         @(posedge clk); #1; e++;
      end
      chk("done_cycle", SRAM_W'(e), SRAM_W'(v.exp_done));
      chk("busy_at_done", SRAM_W'(busy), 0);
      chk("done_after_last_pop", SRAM_W'(cyc - last_pop_cyc), 1);
      chk("words_left", SRAM_W'(exp_data_q.size()), 0);
      chk("reads_left", SRAM_W'(exp_addr_q.size()), 0);
      @(posedge clk); #1;
      chk("done_is_pulse", SRAM_W'(done), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},  SRAM_W'(busy), 0);
      chk({tag, "_done"},  SRAM_W'(done), 0);
      chk({tag, "_valid"}, SRAM_W'(valid), 0);
      chk({tag, "_cen"},   SRAM_W'(cen), 1);
      chk({tag, "_rdwen"}, SRAM_W'(rdwen), 1);
      chk({tag, "_addr"},  SRAM_W'(addr), 0);
      chk({tag, "_data"},  data, 0);
   endtask

   initial begin
      int w;
      logic saw_done;
      vecs.push_back('{base: 10'h010, count: 11'd4, stride: 10'd1, stall: 0,
                       exp_lat: 3, exp_cen: 0, exp_done: 7});
      vecs.push_back('{base: 10'h010, count: 11'd4, stride: 10'd1, stall: 5,
                       exp_lat: 3, exp_cen: 2, exp_done: 12});
      vecs.push_back('{base: 10'h3FE, count: 11'd4, stride: 10'd1, stall: 0,
                       exp_lat: 3, exp_cen: 0, exp_done: 7});
      vecs.push_back('{base: 10'h000, count: 11'd1, stride: 10'd1, stall: 0,
                       exp_lat: 3, exp_cen: 0, exp_done: 4});
      vecs.push_back('{base: 10'h100, count: 11'd7, stride: 10'd1, stall: 2,
                       exp_lat: 3, exp_cen: 2, exp_done: 12});
`ifdef SRAM_RDS_STRIDE_EN
      vecs.push_back('{base: 10'h000, count: 11'd3, stride: 10'd3, stall: 0,
                       exp_lat: 3, exp_cen: 0, exp_done: 6});
      vecs.push_back('{base: 10'h055, count: 11'd3, stride: 10'd0, stall: 1,
                       exp_lat: 3, exp_cen: 2, exp_done: 7});
`endif

      rstn = 1'b0; start = 1'b0; base = '0; count = '0; stride = 10'd1; ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rstn = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Zero-length command: immediate done, no reads, never busy.
      @(posedge clk); #1;
      start = 1'b1; base = 10'h123; count = '0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_done", SRAM_W'(done), 1);
      chk("zero_busy", SRAM_W'(busy), 0);
      chk("zero_cen", SRAM_W'(cen), 1);
      @(posedge clk); #1;
      chk("zero_done_pulse", SRAM_W'(done), 0);
      chk("zero_busy_after", SRAM_W'(busy), 0);

      // Reset in the middle of a long transfer.
      load_expect(10'h010, 11'd8, 10'd1);
      pops = 0;
      start = 1'b1; base = 10'h010; count = 11'd8; stride = 10'd1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      w = 0;
      while (pops < 2 && w < 20) begin
         @(posedge clk); #1; w++;
      end
      chk("two_words_before_reset", SRAM_W'(pops >= 2), 1);
      rstn = 1'b0;
      @(posedge clk); #1;
      chk_reset_vals("midreset");
      exp_addr_q.delete();
      exp_data_q.delete();
      saw_done = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (done || busy || valid) saw_done = 1'b1;
      end
      chk("quiet_after_reset", SRAM_W'(saw_done), 0);
      run_vec('{base: 10'h020, count: 11'd2, stride: 10'd1, stall: 0,
                exp_lat: 3, exp_cen: 0, exp_done: 5});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_rd_streamer.md
# sram_rd_streamer

Read-side streaming front-end for the `ram_inferred` SRAM macro in the SAURIA core. It turns a start command (base address, word count) into a sequence of active-low chip-enable read accesses on the SRAM port. It absorbs the SRAM's one-cycle registered read latency and presents the words in order on a valid/ready stream toward the array feeders. Backpressure is handled by a 2-entry output FIFO and credit-based issue, so no read word is ever dropped or re-read.

## Interface
- `ADR_W`, 10, SRAM address width.
- `SRAM_W`, 128, SRAM word width.
- `CNT_W`, `ADR_W+1`, transfer length width; allows a full-memory transfer.

- `i_clk` in 1: single clock.
- `i_rstn` in 1: reset, synchronous, active-low.
- `i_start` in 1: one-cycle command strobe; sampled only in IDLE.
- `i_base_addr` in ADR_W: first address.
- `i_count` in CNT_W: number of words.
- `i_stride` in ADR_W: address increment; present only with `SRAM_RDS_STRIDE_EN`.
- `o_busy` out 1: high from the accepted start until done.
- `o_done` out 1: one-cycle pulse at transfer completion.
- `o_sram_cen` out 1: SRAM chip enable, active-low.
- `o_sram_rdwen` out 1: SRAM read/write select; tied to 1 (read).
- `o_sram_addr` out ADR_W: SRAM address.
- `i_sram_rdata` in SRAM_W: SRAM read data, valid one cycle after a `cen`-low edge.
- `o_data` out SRAM_W: stream data.
- `o_valid` out 1: stream valid.
- `i_ready` in 1: stream ready.

## Operation
- **FSM states.**
  - IDLE: `i_start` with `i_count != 0` latches the base, count and stride, then moves to ISSUE. `i_start` with `i_count == 0` pulses `o_done` the next cycle and stays in IDLE.
  - ISSUE: issues at most one read per cycle when `credit_ok`. After the last issue it moves to DRAIN.
  - DRAIN: when the FIFO is empty, no read is pending and no pop occurs, it returns to IDLE and pulses `o_done` in the same cycle.
- **Issue condition.** `credit_ok = (pending + fifo_cnt − pop) < 2`.
  - `pending` is the 1-bit flag for a read outstanding in the SRAM.
  - `pop = o_valid & i_ready`.
- **Read issue.** `o_sram_cen = !(state==ISSUE & credit_ok)`. This is combinational, so a path from `i_ready` to `cen` is allowed.
- **Address update.** The address register advances by stride (1 without the macro) on each issue. Arithmetic is modulo 2^ADR_W, so the address wraps silently.
- **Count.** The remaining count decrements on each issue. The last issue is the one taken while remaining == 1.
- **Pending flag.** `pending` is set on the cycle `cen` is low and cleared the next cycle. While `pending` is set, `i_sram_rdata` is pushed into the FIFO.
- **FIFO.** 2 entries, first-word-fall-through. Push and pop in the same cycle is legal. By construction of the credit it never overflows.
- **Command handling.** `i_start` is ignored while busy.
- **Reset mid-operation.** Returns to IDLE, flushes the FIFO and pending read, and produces no `o_done`.

## Timing
- **Reset values.** `o_busy`=0, `o_done`=0, `o_valid`=0, `o_sram_cen`=1, `o_sram_rdwen`=1, `o_sram_addr`=0, `o_data`=0.
- **Latency.** Start sampled at edge E0. `cen` is low in the cycle after E0. Data reaches the RAM output after E1. The FIFO pushes at E2, and `o_valid` is high after E2.
- **Throughput.** 1 word/cycle sustained while `i_ready`=1.
- **Backpressure.** At most 2 reads issue beyond the last pop.
- **Stream rule.** `o_data` is held stable while `o_valid & !i_ready`.
- **Done.** `o_done` is high in the cycle after the final pop edge. `o_busy` falls in the same cycle.

## Configuration
- `SRAM_RDS_STRIDE_EN` defined: the `i_stride` port exists and is latched at start. A stride of 0 re-reads the base address count times.
- Not defined: no `i_stride` port, and the stride is the constant 1.

## Structure
- **Package `sram_rds_pkg`:**
  - state enum (IDLE, ISSUE, DRAIN);
  - `RDS_FIFO_DEPTH = 2`.
- **Sub-module `sram_rds_fifo`:** 2-entry FWFT FIFO parameterised by width, with push/pop/count.

## Test plan
- `mem[a]=a`, base 0x010, count 4, ready=1 → `o_data` 0x010..0x013 on 4 consecutive cycles, first `o_valid` 3 edges after start, `o_done` one cycle after the last pop.
- Same transfer with ready=0 for 5 cycles after the first valid → exactly 2 `cen`-low cycles during the stall, `o_data` stable at 0x010, all 4 words delivered in order.
- Base 0x3FE, count 4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Count 0 → `o_done` pulse the next cycle, `o_sram_cen` stays 1, `o_busy` stays 0.
- Reset asserted mid-transfer after 2 words → all outputs at reset values the next cycle, no done; a new start with base 0x020, count 2 yields 0x020, 0x021.
- With `SRAM_RDS_STRIDE_EN`, stride 3, base 0, count 3 → addresses 0, 3, 6.
